// File: rtl/simon_pkt_rx.sv
// -----------------------------------------------------------------------------
// simon_pkt_rx
//
// Byte-serial packet assembler feeding the SIMON input stage. A byte stream
// with a valid/ready handshake is collected into a fill buffer of PKT_BYTES
// bytes:
//   - N/2 data bytes,
//   - one count byte,
//   - one info byte.
// A full buffer is copied to the parallel output register and announced with
// in_newPKT. The output register and the fill buffer are separate, so the
// next packet fills while the current one is presented.
//
// Compile-time configuration:
//   `N                 SIMON word width (defaults to 16 when not defined).
//   `MODE              Expected mode nibble in info[3:0] (defaults to 4'd0).
//   SIMON_RX_CHECK_EN  When defined, each buffered packet is checked before it
//                      is presented. Rejected packets raise a one-cycle rx_err
//                      pulse. When undefined, every full buffer is presented
//                      and rx_err is tied low.
//
// Ports:
//   clk         in   system clock, rising edge
//   nR          in   asynchronous active-low reset
//   rx_byte     in   [7:0] incoming byte
//   rx_valid    in   rx_byte valid this cycle
//   rx_sof      in   rx_byte is the first byte of a packet (resync)
//   rx_ready    out  block accepts a byte this cycle (= not full)
//   in_loadPKT  in   input stage has captured pkt_out
//   in_donePKT  in   input stage idle, ready for a new packet
//   in_newPKT   out  pkt_out holds a new packet
//   pkt_out     out  [PKT_BYTES*8-1:0] packet; byte 0 is bits [7:0] (first received)
//   pkt_cnt     out  [7:0] packets presented since reset (wraps)
//   rx_err      out  one-cycle pulse on a rejected packet
// -----------------------------------------------------------------------------
`ifndef N
`define N 16
`endif
`ifndef MODE
`define MODE 4'd0
`endif

module simon_pkt_rx #(
  parameter  int N         = `N,
  localparam int PKT_BYTES = (N / 2) + 2,
  localparam int IDX_W     = $clog2(PKT_BYTES)
) (
  input  logic                   clk,
  input  logic                   nR,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  input  logic                   rx_sof,
  output logic                   rx_ready,
  input  logic                   in_loadPKT,
  input  logic                   in_donePKT,
  output logic                   in_newPKT,
  output logic [PKT_BYTES*8-1:0] pkt_out,
  output logic [7:0]             pkt_cnt,
  output logic                   rx_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [PKT_BYTES*8-1:0]   fbuf_r;
  logic [IDX_W-1:0]         idx_r;
  logic                     full_r;
  logic [PKT_BYTES*8-1:0]   pkt_out_r;
  logic [7:0]               pkt_cnt_r;
  logic                     newpkt_r;
  logic                     newpkt_s;
  logic                     accept_s;
  logic                     copy_s;
  logic                     reject_s;
  logic                     pkt_ok_s;

`ifdef SIMON_RX_CHECK_EN
  localparam int         CNT_LO  = (N / 2) * 8;
  localparam int         INFO_LO = ((N / 2) + 1) * 8;
  localparam logic [3:0] MODE_V  = `MODE;

  logic [7:0] exp_cnt_r;
  logic       rx_err_r;

  // Packet acceptance rule. A packet is accepted only if all of these hold:
  //   - the count byte matches the expected sequence number,
  //   - the mode nibble matches,
  //   - the info direction bit marks it as an input packet.
  function automatic logic pkt_check(
    input logic [7:0] cnt_b,
    input logic [4:0] info_lo,
    input logic [7:0] exp_cnt
  );
    pkt_check = (cnt_b == exp_cnt) &&
                (info_lo[3:0] == MODE_V) &&
                (info_lo[4] == 1'b0);
  endfunction

  assign pkt_ok_s = pkt_check(fbuf_r[CNT_LO +: 8], fbuf_r[INFO_LO +: 5], exp_cnt_r);
  assign rx_err   = rx_err_r;
`else
  assign pkt_ok_s = 1'b1;
  assign rx_err   = 1'b0;
`endif

  // The ready signal comes straight from the full flag. While the buffer is
  // full, nothing is accepted (not even a resync byte). A copy and a byte
  // accept therefore can never occur in the same cycle.
  assign rx_ready  = ~full_r;
  assign accept_s  = rx_valid & ~full_r;
  assign in_newPKT = newpkt_r;
  assign pkt_out   = pkt_out_r;
  assign pkt_cnt   = pkt_cnt_r;

  // Fill buffer, fill index and full flag.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      fbuf_r <= '0;
      idx_r  <= '0;
      full_r <= 1'b0;
    end else if (accept_s) begin
      if (rx_sof) begin
        // Resync: restart the packet at byte 0 and drop any partial fill.
        fbuf_r[7:0] <= rx_byte;
        idx_r       <= IDX_W'(1);
      end else begin
        for (int i = 0; i < PKT_BYTES; i++) begin
          if (idx_r == IDX_W'(i)) begin
            fbuf_r[i*8 +: 8] <= rx_byte;
          end
        end
        if (idx_r == LAST_IDX) begin
          idx_r  <= '0;
          full_r <= 1'b1;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
    end else if (copy_s || reject_s) begin
      full_r <= 1'b0;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output FSM: next state, copy/reject strobes and the next in_newPKT value.
  always_comb begin
    state_s  = state_r;
    newpkt_s = newpkt_r;
    copy_s   = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r && in_donePKT && !in_loadPKT) begin
          if (pkt_ok_s) begin
            copy_s   = 1'b1;
            newpkt_s = 1'b1;
            state_s  = ST_PRESENT;
          end else begin
            reject_s = 1'b1;
            state_s  = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (in_loadPKT) begin
          newpkt_s = 1'b0;
          state_s  = ST_RELEASE;
        end else begin
          newpkt_s = 1'b1;
          state_s  = ST_PRESENT;
        end
      end
      ST_RELEASE: begin
        // Wait for load to drop, so the next in_newPKT starts with a fresh
        // rising edge.
        newpkt_s = 1'b0;
        if (!in_loadPKT) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        newpkt_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // Output register, packet counter and in_newPKT flag. pkt_out is loaded
  // only on the copy edge.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      pkt_out_r <= '0;
      pkt_cnt_r <= 8'd0;
      newpkt_r  <= 1'b0;
    end else begin
      newpkt_r <= newpkt_s;
      if (copy_s) begin
        pkt_out_r <= fbuf_r;
        pkt_cnt_r <= pkt_cnt_r + 8'd1;
      end else begin
        pkt_out_r <= pkt_out_r;
        pkt_cnt_r <= pkt_cnt_r;
      end
    end
  end

`ifdef SIMON_RX_CHECK_EN
  // Expected-count tracker and error pulse. The expected count advances only
  // on accepted packets.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      exp_cnt_r <= 8'd0;
      rx_err_r  <= 1'b0;
    end else begin
      rx_err_r <= reject_s;
      if (copy_s) begin
        exp_cnt_r <= exp_cnt_r + 8'd1;
      end else begin
        exp_cnt_r <= exp_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_simon_pkt_rx.sv
module tb_simon_pkt_rx;

  localparam int PB = 10;

  logic          clk;
  logic          nR;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_sof;
  logic          rx_ready;
  logic          in_loadPKT;
  logic          in_donePKT;
  logic          in_newPKT;
  logic [PB*8-1:0] pkt_out;
  logic [7:0]    pkt_cnt;
  logic          rx_err;

  int total;
  int bad;

  simon_pkt_rx #(.N(16)) dut (
    .clk        (clk),
    .nR         (nR),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_ready   (rx_ready),
    .in_loadPKT (in_loadPKT),
    .in_donePKT (in_donePKT),
    .in_newPKT  (in_newPKT),
    .pkt_out    (pkt_out),
    .pkt_cnt    (pkt_cnt),
    .rx_err     (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet whose byte i equals base+i.
  function automatic logic [PB*8-1:0] mk(input logic [7:0] base);
    logic [PB*8-1:0] r;
    for (int i = 0; i < PB; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  // Offer one byte for exactly one clock edge; returns 1 time unit after it.
  task automatic send_byte(input logic [7:0] b, input logic sof);
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_sof   = sof;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base);
    for (int i = 0; i < PB; i++) send_byte(base + 8'(i), 1'b0);
  endtask

  task automatic release_pkt(input string name);
    in_loadPKT = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: in_newPKT=%b expected 0", name, in_newPKT);
    end
    in_loadPKT = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    nR = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_sof = 1'b0;
    in_loadPKT = 1'b0; in_donePKT = 1'b1;
    #3;
    total++;
    if (in_newPKT !== 1'b0 || pkt_out !== '0 || pkt_cnt !== 8'd0 || rx_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: newPKT=%b pkt_out=%h cnt=%0d err=%b expected all 0",
               in_newPKT, pkt_out, pkt_cnt, rx_err);
    end
    repeat (2) @(posedge clk);
    #1 nR = 1'b1;
    #1;
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: rx_ready=%b expected 1", rx_ready);
    end
  endtask

`ifndef SIMON_RX_CHECK_EN
  task automatic test_basic;
    send_pkt(8'h00);
    total++;
    if (in_newPKT !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_full: newPKT=%b rx_ready=%b expected 0/0", in_newPKT, rx_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h00) || pkt_cnt !== 8'd1) begin
      bad++;
      $display("FAIL basic_present: newPKT=%b pkt_out=%h cnt=%0d expected 1 %h 1",
               in_newPKT, pkt_out, pkt_cnt, mk(8'h00));
    end
    total++;
    if (rx_ready !== 1'b1 || rx_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_ready: rx_ready=%b rx_err=%b expected 1/0", rx_ready, rx_err);
    end
    release_pkt("basic");
  endtask

  task automatic test_backpressure;
    in_donePKT = 1'b0;
    send_pkt(8'h10);
    total++;
    if (rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_low: rx_ready=%b expected 0", rx_ready);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    total++;
    if (in_newPKT !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_held: newPKT=%b rx_ready=%b expected 0/0", in_newPKT, rx_ready);
    end
    in_donePKT = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h10) || rx_ready !== 1'b1 || pkt_cnt !== 8'd2) begin
      bad++;
      $display("FAIL bp_present: newPKT=%b pkt_out=%h ready=%b cnt=%0d expected 1 %h 1 2",
               in_newPKT, pkt_out, rx_ready, pkt_cnt, mk(8'h10));
    end
    release_pkt("bp");
  endtask

  task automatic test_sof;
    logic [PB*8-1:0] exp;
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0);
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i < PB; i++) send_byte(8'h40 + 8'(i), 1'b0);
    exp = mk(8'h40);
    exp[7:0] = 8'hA5;
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== exp || pkt_cnt !== 8'd3) begin
      bad++;
      $display("FAIL sof_present: newPKT=%b pkt_out=%h cnt=%0d expected 1 %h 3",
               in_newPKT, pkt_out, pkt_cnt, exp);
    end
    release_pkt("sof");
  endtask

  task automatic test_back_to_back;
    int errs;
    send_pkt(8'h50);
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h50) || pkt_cnt !== 8'd4) begin
      bad++;
      $display("FAIL b2b_first: newPKT=%b pkt_out=%h cnt=%0d expected 1 %h 4",
               in_newPKT, pkt_out, pkt_cnt, mk(8'h50));
    end
    errs = 0;
    for (int i = 0; i < PB; i++) begin
      send_byte(8'h60 + 8'(i), 1'b0);
      if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h50)) errs++;
    end
    in_loadPKT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (in_newPKT !== 1'b0 || pkt_out !== mk(8'h50)) errs++;
    end
    in_loadPKT = 1'b0;
    @(posedge clk); #1;
    if (in_newPKT !== 1'b0) errs++;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL b2b_hold: %0d cycles with wrong newPKT/pkt_out, expected 0", errs);
    end
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h60) || pkt_cnt !== 8'd5) begin
      bad++;
      $display("FAIL b2b_second: newPKT=%b pkt_out=%h cnt=%0d expected 1 %h 5",
               in_newPKT, pkt_out, pkt_cnt, mk(8'h60));
    end
    release_pkt("b2b");
  endtask

  task automatic test_reset_mid;
    send_pkt(8'h80);
    @(posedge clk); #1;
    nR = 1'b0;
    #2;
    total++;
    if (in_newPKT !== 1'b0 || pkt_out !== '0 || pkt_cnt !== 8'd0 || rx_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_present: newPKT=%b pkt_out=%h cnt=%0d err=%b expected all 0",
               in_newPKT, pkt_out, pkt_cnt, rx_err);
    end
    @(posedge clk); #1 nR = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i), 1'b0);
    nR = 1'b0;
    #2;
    total++;
    if (in_newPKT !== 1'b0 || pkt_out !== '0 || pkt_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_fill: newPKT=%b pkt_out=%h cnt=%0d expected all 0",
               in_newPKT, pkt_out, pkt_cnt);
    end
    @(posedge clk); #1 nR = 1'b1;
    send_pkt(8'h70);
    @(posedge clk); #1;
    total++;
    if (in_newPKT !== 1'b1 || pkt_out !== mk(8'h70) || pkt_cnt !== 8'd1) begin
      bad++;
      $display("FAIL rst_after: newPKT=%b pkt_out=%h cnt=%0d expected 1 %h 1",
               in_newPKT, pkt_out, pkt_cnt, mk(8'h70));
    end
    release_pkt("rst");
  endtask

  task automatic test_wrap;
    for (int p = 0; p < 254; p++) begin
      send_pkt(8'(p));
      @(posedge clk); #1;
      release_pkt("wrap_loop");
    end
    total++;
    if (pkt_cnt !== 8'd255) begin
      bad++;
      $display("FAIL wrap_255: pkt_cnt=%0d expected 255", pkt_cnt);
    end
    send_pkt(8'hC0);
    @(posedge clk); #1;
    total++;
    if (pkt_cnt !== 8'd0 || in_newPKT !== 1'b1 || pkt_out !== mk(8'hC0)) begin
      bad++;
      $display("FAIL wrap_0: cnt=%0d newPKT=%b pkt_out=%h expected 0 1 %h",
               pkt_cnt, in_newPKT, pkt_out, mk(8'hC0));
    end
    release_pkt("wrap");
  endtask
`else
`ifndef MODE
`define MODE 4'd0
`endif
  task automatic send_chk(input logic [7:0] cnt, input logic [7:0] info);
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1'b0);
    send_byte(cnt, 1'b0);
    send_byte(info, 1'b0);
  endtask

  task automatic test_check;
    logic [3:0]      mode_v;
    logic [7:0]      info;
    logic [PB*8-1:0] exp;
    mode_v = `MODE;
    info   = {4'h0, mode_v};
    send_chk(8'h01, info);
    @(posedge clk); #1;
    total++;
    if (rx_err !== 1'b1 || in_newPKT !== 1'b0 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL chk_reject: err=%b newPKT=%b ready=%b expected 1 0 1", rx_err, in_newPKT, rx_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rx_err !== 1'b0 || pkt_cnt !== 8'd0 || in_newPKT !== 1'b0) begin
      bad++;
      $display("FAIL chk_pulse: err=%b cnt=%0d newPKT=%b expected 0 0 0", rx_err, pkt_cnt, in_newPKT);
    end
    send_chk(8'h00, info);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp[i*8 +: 8] = 8'h11 + 8'(i);
    exp[71:64] = 8'h00;
    exp[79:72] = info;
    total++;
    if (in_newPKT !== 1'b1 || pkt_cnt !== 8'd1 || rx_err !== 1'b0 || pkt_out !== exp) begin
      bad++;
      $display("FAIL chk_accept: newPKT=%b cnt=%0d err=%b pkt_out=%h expected 1 1 0 %h",
               in_newPKT, pkt_cnt, rx_err, pkt_out, exp);
    end
    release_pkt("chk");
    send_chk(8'h01, info | 8'h10);
    @(posedge clk); #1;
    total++;
    if (rx_err !== 1'b1 || in_newPKT !== 1'b0 || pkt_cnt !== 8'd1) begin
      bad++;
      $display("FAIL chk_dir: err=%b newPKT=%b cnt=%0d expected 1 0 1", rx_err, in_newPKT, pkt_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
`ifdef SIMON_RX_CHECK_EN
    test_check();
`else
    test_basic();
    test_backpressure();
    test_sof();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_pkt_rx.md
Name: simon_pkt_rx

Overview:
Byte-serial packet assembler sitting directly upstream of the SIMON input stage. Accepts a byte stream with valid/ready handshake and assembles PKT_BYTES bytes into one packet. Presents the packet on a parallel bus with the in_newPKT / in_loadPKT / in_donePKT handshake that the input stage consumes. Double-buffered, so the next packet fills while the current one is presented.

Parameters:
N, `N, SIMON word width in bits.
PKT_BYTES, (N/2)+2, bytes per packet: N/2 data bytes, then count byte, then info byte.
IDX_W, $clog2(PKT_BYTES), width of the fill index.

Ports:
clk  input  1  system clock, rising edge
nR  input  1  asynchronous active-low reset
rx_byte  input  8  incoming byte
rx_valid  input  1  rx_byte valid this cycle
rx_sof  input  1  qualifies rx_byte as first byte of a packet (resync)
rx_ready  output  1  block can accept a byte this cycle
in_loadPKT  input  1  input stage has captured pkt_out
in_donePKT  input  1  input stage idle, ready for a new packet
in_newPKT  output  1  pkt_out holds a new packet
pkt_out  output  PKT_BYTES*8  assembled packet; byte i is bits [8i+7:8i], byte 0 is first received
pkt_cnt  output  8  packets presented since reset
rx_err  output  1  one-cycle pulse on rejected packet (SIMON_RX_CHECK_EN only)

Behaviour:
- Reset (nR low, async): in_newPKT=0, pkt_out=0, pkt_cnt=0, rx_err=0, fill buffer=0, idx=0, full=0, FSM=IDLE. A partially filled packet is discarded. rx_ready is 1 once nR is released.
- Fill side:
  - rx_ready = ~full (combinational).
  - A byte is accepted when rx_valid && rx_ready. It is written to fbuf[idx] and idx increments.
  - If the accepted byte has rx_sof=1, it is written to fbuf[0] and idx becomes 1, discarding any partial fill.
  - When the byte at idx=PKT_BYTES-1 is accepted, full<=1 and idx<=0 on the same edge.
  - While full, bytes are not accepted, including bytes with rx_sof.
- Output FSM states are IDLE, PRESENT and RELEASE.
  - IDLE: when full && in_donePKT && ~in_loadPKT: pkt_out<=fbuf, full<=0, in_newPKT<=1, pkt_cnt<=pkt_cnt+1 (8-bit, wraps 255->0), go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: in_newPKT held 1 and pkt_out held stable. When in_loadPKT=1: in_newPKT<=0, go to RELEASE.
  - RELEASE: wait for in_loadPKT=0, then go to IDLE. This guarantees a clean new rising edge on in_newPKT for the next packet.
- Latency: last byte accepted at edge k gives full=1 after k. If the input stage is idle, pkt_out and in_newPKT update at edge k+1.
- Overlap: rx_ready returns to 1 on the copy edge, so filling of the next packet starts the cycle after the copy. Because rx_ready=0 in the copy cycle, a copy and a byte accept never coincide.
- pkt_out changes only on the IDLE->PRESENT copy edge. It is never modified while in_newPKT=1.
- If in_donePKT is low, full packets wait in fbuf. The stream back-pressures through rx_ready with no loss.

Optional Feature:
Macro SIMON_RX_CHECK_EN.
- With the macro: on the IDLE copy condition the buffered packet is checked first. It is rejected if any of the following holds:
  - count byte (byte N/2) != expected count. Expected count starts at 0 and increments only on accepted packets.
  - info[3:0] != `MODE.
  - info[4]=1 (output packet).
- On rejection: full<=0, no copy, in_newPKT stays 0, pkt_cnt is unchanged, rx_err pulses for one cycle, FSM stays in IDLE.
- Accepted packets behave exactly as the base block.
- Without the macro: no checks, rx_err tied to 0, every full buffer is presented.

Test Plan:
- N=16 (PKT_BYTES=10), input stage idle (in_donePKT=1): stream bytes 0x00..0x09 back-to-back -> one cycle after the last byte, in_newPKT=1, pkt_out byte i = i, pkt_cnt=1. Then pulse in_loadPKT high 1 cycle -> in_newPKT=0 the next cycle.
- Hold in_donePKT=0 and send 10 bytes, then 3 more offered -> rx_ready=0 after byte 10, 3 bytes not accepted, in_newPKT=0. Raise in_donePKT -> presented next cycle, rx_ready=1.
- Send 4 bytes, then a byte 0xA5 with rx_sof=1 plus 9 more -> pkt_out byte 0 = 0xA5, the first 4 bytes absent.
- Two packets back-to-back with in_loadPKT held high 3 cycles -> second in_newPKT rises only after in_loadPKT falls. pkt_out is unchanged while in_newPKT=1. pkt_cnt=2.
- Assert nR low mid-fill (byte 5) and mid-PRESENT -> all outputs 0 immediately. The next full packet presents correctly with pkt_cnt=1.
- SIMON_RX_CHECK_EN: packet with count byte 0x01 as the first packet -> rx_err pulse, no in_newPKT. A following packet with count 0x00 and correct mode is presented.
